// File: rtl/systolic_operand_skew.sv
// Operand-feed skew for the N1 x N2 systolic array: per-bank read address/enable
// delayed by lane index, plus a per-PE init pulse delayed by x+y+1 cycles.
module systolic_operand_skew #(
  parameter int D_W = 8,
  parameter int N1  = 4,
  parameter int N2  = 4,
  parameter int M   = 8,
  localparam int AW_A = $clog2(M*M/N1),
  localparam int AW_B = $clog2(M*M/N2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW_A-1:0]   rd_addr_A,
  input  logic [AW_B-1:0]   rd_addr_B,
  input  logic              init_in,
  output logic [AW_A-1:0]   rd_addr_A_bram [N1-1:0],
  output logic [N1-1:0]     rd_en_A_bram,
  output logic [AW_B-1:0]   rd_addr_B_bram [N2-1:0],
  output logic [N2-1:0]     rd_en_B_bram,
  output logic [N1*N2-1:0]  init_pe
);

  localparam int INIT_D = N1 + N2 - 1;

  // The bank split assumes whole tiles; D_W has no datapath here.
  if ((M % N1) != 0 || (M % N2) != 0 || D_W < 1) begin : g_bad_cfg
    $error("systolic_operand_skew: M must be divisible by N1 and N2, D_W >= 1");
  end

  // A lanes: lane 0 is a wire, lane i carries {en, addr} through i registers.
  for (genvar i = 0; i < N1; i++) begin : g_lane_a
    if (i == 0) begin : g_pass
      assign rd_addr_A_bram[0] = rd_addr_A;
      assign rd_en_A_bram[0]   = rd_en;
    end else begin : g_dly
      logic [AW_A:0] stage [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) stage[k] <= '0;
        end else begin
          stage[0] <= {rd_en, rd_addr_A};
          for (int k = 1; k < i; k++) stage[k] <= stage[k-1];
        end
      end
      assign {rd_en_A_bram[i], rd_addr_A_bram[i]} = stage[i-1];
    end
  end

  for (genvar j = 0; j < N2; j++) begin : g_lane_b
    if (j == 0) begin : g_pass
      assign rd_addr_B_bram[0] = rd_addr_B;
      assign rd_en_B_bram[0]   = rd_en;
    end else begin : g_dly
      logic [AW_B:0] stage [j];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < j; k++) stage[k] <= '0;
        end else begin
          stage[0] <= {rd_en, rd_addr_B};
          for (int k = 1; k < j; k++) stage[k] <= stage[k-1];
        end
      end
      assign {rd_en_B_bram[j], rd_addr_B_bram[j]} = stage[j-1];
    end
  end

  // One shared init chain; every PE on the same anti-diagonal taps the same stage.
  logic [INIT_D:1] init_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q <= '0;
    end else begin
      init_q[1] <= init_in;
      for (int k = 2; k <= INIT_D; k++) init_q[k] <= init_q[k-1];
    end
  end

  for (genvar x = 0; x < N1; x++) begin : g_pe_row
    for (genvar y = 0; y < N2; y++) begin : g_pe_col
      assign init_pe[x*N2+y] = init_q[x+y+1];
    end
  end

endmodule

// File: tb/tb_systolic_operand_skew.sv
// Self-checking bench: default 4x4 instance plus an asymmetric 2x4 instance,
// checked every cycle against an input-history model and pinned with literals.
module tb_systolic_operand_skew;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;
  logic init_in = 1'b0;
  logic [3:0] rd_addr_A = '0;
  logic [3:0] rd_addr_B = '0;
  logic [4:0] rd_addr_A2 = '0;

  logic [3:0]  a_bram [3:0];
  logic [3:0]  en_a;
  logic [3:0]  b_bram [3:0];
  logic [3:0]  en_b;
  logic [15:0] init_pe;

  logic [4:0]  a2_bram [1:0];
  logic [1:0]  en_a2;
  logic [3:0]  b2_bram [3:0];
  logic [3:0]  en_b2;
  logic [7:0]  init_pe2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_operand_skew dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .init_in(init_in), .rd_addr_A_bram(a_bram), .rd_en_A_bram(en_a),
    .rd_addr_B_bram(b_bram), .rd_en_B_bram(en_b), .init_pe(init_pe)
  );

  systolic_operand_skew #(.D_W(8), .N1(2), .N2(4), .M(8)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_A(rd_addr_A2), .rd_addr_B(rd_addr_B),
    .init_in(init_in), .rd_addr_A_bram(a2_bram), .rd_en_A_bram(en_a2),
    .rd_addr_B_bram(b2_bram), .rd_en_B_bram(en_b2), .init_pe(init_pe2)
  );

  // Model: h_*[k] holds the input seen k+1 edges ago; reset wipes the history.
  logic       h_en   [8] = '{default: '0};
  logic       h_init [8] = '{default: '0};
  logic [3:0] h_a    [8] = '{default: '0};
  logic [3:0] h_b    [8] = '{default: '0};
  logic [4:0] h_a2   [8] = '{default: '0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        h_en[k] <= 1'b0; h_init[k] <= 1'b0; h_a[k] <= '0; h_b[k] <= '0; h_a2[k] <= '0;
      end
    end else begin
      h_en[0] <= rd_en; h_init[0] <= init_in;
      h_a[0] <= rd_addr_A; h_b[0] <= rd_addr_B; h_a2[0] <= rd_addr_A2;
      for (int k = 1; k < 8; k++) begin
        h_en[k] <= h_en[k-1]; h_init[k] <= h_init[k-1];
        h_a[k] <= h_a[k-1]; h_b[k] <= h_b[k-1]; h_a2[k] <= h_a2[k-1];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_addr_A[%0d]", i), a_bram[i], (i == 0) ? rd_addr_A : h_a[i-1]);
      chk($sformatf("model_en_A[%0d]", i), en_a[i], (i == 0) ? rd_en : h_en[i-1]);
      chk($sformatf("model_addr_B[%0d]", i), b_bram[i], (i == 0) ? rd_addr_B : h_b[i-1]);
      chk($sformatf("model_en_B[%0d]", i), en_b[i], (i == 0) ? rd_en : h_en[i-1]);
      chk($sformatf("model2_addr_B[%0d]", i), b2_bram[i], (i == 0) ? rd_addr_B : h_b[i-1]);
      chk($sformatf("model2_en_B[%0d]", i), en_b2[i], (i == 0) ? rd_en : h_en[i-1]);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model2_addr_A[%0d]", i), a2_bram[i], (i == 0) ? rd_addr_A2 : h_a2[i-1]);
      chk($sformatf("model2_en_A[%0d]", i), en_a2[i], (i == 0) ? rd_en : h_en[i-1]);
    end
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        chk($sformatf("model_init_pe(%0d,%0d)", x, y), init_pe[x*4+y], h_init[x+y]);
        if (x < 2)
          chk($sformatf("model2_init_pe(%0d,%0d)", x, y), init_pe2[x*4+y], h_init[x+y]);
      end
  endtask

  always @(negedge clk) check_all();

  task automatic drive(input logic en, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] a2, input logic ini);
    @(posedge clk);
    #2;
    rd_en = en; rd_addr_A = a; rd_addr_B = b; rd_addr_A2 = a2; init_in = ini;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [3:0] en_ramp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [3:0] en_walk [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  int cnt1 [16];
  int cnt2 [8];

  initial begin
    // Reset values with lane 0 passing through
    #1;
    rst = 1'b0; rd_en = 1'b1; rd_addr_A = 4'd5; rd_addr_B = 4'd5; rd_addr_A2 = 5'd5;
    settle();
    chk("rst_en_A", en_a, 4'b0001);
    chk("rst_addr_A0", a_bram[0], 5);
    for (int i = 1; i < 4; i++) chk($sformatf("rst_addr_A%0d", i), a_bram[i], 0);
    chk("rst_en_B", en_b, 4'b0001);
    chk("rst_init_pe", init_pe, 0);
    chk("rst_init_pe2", init_pe2, 0);

    drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Address skew ramp
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'(k), 4'(k), 5'(2*k+1), 1'b0);
      settle();
      if (k < 4) begin
        chk("skew_en_A", en_a, en_ramp[k]);
        chk("skew_en_B", en_b, en_ramp[k]);
      end
      if (k == 3) begin
        chk("skew_A3_first", a_bram[3], 0);
        chk("skew_A0_at3", a_bram[0], 3);
        chk("skew_A2_at3", a_bram[2], 1);
      end
      if (k == 15) begin
        chk("skew_A3_at15", a_bram[3], 12);
        chk("skew_B2_at15", b_bram[2], 13);
        chk("skew2_A1_at15", a2_bram[1], 29);
      end
    end

    // Single enable pulse walks across B lanes
    repeat (4) drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
    drive(1'b1, 4'd0, 4'd9, 5'd0, 1'b0);
    settle();
    chk("pulse_en_B_t0", en_b, en_walk[0]);
    for (int j = 1; j < 5; j++) begin
      drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
      settle();
      chk($sformatf("pulse_en_B_t%0d", j), en_b, en_walk[j]);
      if (j == 3) chk("pulse_addr_B3", b_bram[3], 9);
    end

    // Init fan-out (both configurations)
    for (int b = 0; b < 16; b++) cnt1[b] = 0;
    for (int b = 0; b < 8; b++) cnt2[b] = 0;
    drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b1);
    settle();
    chk("init_t0", init_pe, 16'h0000);
    for (int c = 1; c < 10; c++) begin
      drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
      settle();
      for (int b = 0; b < 16; b++) cnt1[b] += int'(init_pe[b]);
      for (int b = 0; b < 8; b++) cnt2[b] += int'(init_pe2[b]);
      if (c == 1) begin
        chk("init_t1", init_pe, 16'h0001);
        chk("init2_t1", init_pe2, 8'h01);
      end
      if (c == 4) chk("init_t4", init_pe, 16'h1248);
      if (c == 5) begin
        chk("init_t5", init_pe, 16'h2480);
        chk("init2_t5", init_pe2, 8'h80);
      end
      if (c == 7) chk("init_t7", init_pe, 16'h8000);
    end
    for (int b = 0; b < 16; b++) chk($sformatf("init_count[%0d]", b), cnt1[b], 1);
    for (int b = 0; b < 8; b++) chk($sformatf("init2_count[%0d]", b), cnt2[b], 1);

    // Asynchronous reset mid-stream
    drive(1'b1, 4'd1, 4'd1, 5'd1, 1'b1);
    for (int k = 1; k < 4; k++) drive(1'b1, 4'(k+1), 4'(k+1), 5'(k+1), 1'b0);
    settle();
    chk("pre_rst_init", init_pe, 16'h0124);
    chk("pre_rst_A3", a_bram[3], 1);
    chk("pre_rst_en_A", en_a, 4'b1111);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_init", init_pe, 16'h0000);
    chk("mid_rst_init2", init_pe2, 8'h00);
    chk("mid_rst_en_A", en_a, 4'b0001);
    chk("mid_rst_en_B", en_b, 4'b0001);
    chk("mid_rst_A0", a_bram[0], 4);
    for (int i = 1; i < 4; i++) chk($sformatf("mid_rst_A%0d", i), a_bram[i], 0);
    check_all();
    @(posedge clk);
    #2 rd_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
      settle();
      chk("post_rst_init", init_pe, 16'h0000);
      chk("post_rst_init2", init_pe2, 8'h00);
      chk("post_rst_en_A", en_a, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_operand_skew.md
# systolic_operand_skew

Operand-feed timing block for the N1×N2 systolic array. It fans a single read address and read enable per operand out to per-row (A) and per-column (B) BRAM banks, delaying lane i by i cycles so operands enter the array on the diagonal wavefront. It also distributes a one-cycle PE-init pulse to every PE(x,y), delayed by x+y+1 cycles. It sits between the array's address/counter logic and the A/B operand BRAMs.

## Interface
- `D_W`, 8: operand data width. Carried for consistency only; no datapath uses it.
- `N1`, 4: array rows, which is also the number of A banks.
- `N2`, 4: array columns, which is also the number of B banks.
- `M`, 8: matrix dimension. Must be divisible by N1 and N2.
- Derived: `AW_A` = $clog2(M*M/N1) and `AW_B` = $clog2(M*M/N2). With the defaults both are 4.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low. Clears all pipeline state.
- `rd_en`, in, 1: common read enable for both operands.
- `rd_addr_A`, in, AW_A: base read address for the A banks.
- `rd_addr_B`, in, AW_B: base read address for the B banks.
- `init_in`, in, 1: PE-init pulse. Driven high for one cycle after the last pixel of a slice.
- `rd_addr_A_bram`, out, AW_A × [N1-1:0] (unpacked): per-bank A address.
- `rd_en_A_bram`, out, [N1-1:0]: per-bank A enable.
- `rd_addr_B_bram`, out, AW_B × [N2-1:0] (unpacked): per-bank B address.
- `rd_en_B_bram`, out, [N2-1:0]: per-bank B enable.
- `init_pe`, out, [N1*N2-1:0]: per-PE init. Bit x*N2+y drives PE(x,y).

## Operation
- **A lane i (0..N1-1):** `rd_addr_A_bram[i]` and `rd_en_A_bram[i]` equal `rd_addr_A` and `rd_en` delayed by exactly i clock cycles.
- **B lane j (0..N2-1):** `rd_addr_B_bram[j]` and `rd_en_B_bram[j]` equal `rd_addr_B` and `rd_en` delayed by exactly j clock cycles.
- **Lane 0 (A and B):** pure combinational pass-through with no register. It is unaffected by reset.
- **Lanes i≥1:** implemented as an i-deep shift register. Address and enable shift together, so they stay aligned. Addresses pass through unmodified: no offset is added here, because the bank-base offset belongs to the BRAM side.
- **`init_pe` bit x*N2+y:** `init_in` delayed by x+y+1 cycles, using one dedicated shift chain per PE. Chains may share taps if the cycle behaviour is identical.
- **No arithmetic and no wrap logic.** Address wrap-around is the upstream counter's responsibility and is passed through bit-exact.

## Timing
- **While `rst`=0 (asserted):**
  - Every register clears to 0 immediately, without waiting for a clock edge.
  - All lane≥1 addresses and enables read 0, and all `init_pe` bits read 0.
  - Lane-0 outputs follow their inputs.
- **After `rst` rises:** register contents are 0. For the first i cycles, lane i outputs 0 and its enable is 0, which means no spurious BRAM read.
- **Latency:**
  - A lane i: i cycles. B lane j: j cycles.
  - PE(x,y) init: x+y+1 cycles.
  - Maximum `init_pe` latency is N1+N2-1, which is 7 with the defaults.
- **Throughput:** one new address per cycle. Back-to-back `init_in` pulses produce back-to-back pulses at each output. No handshake and no back-pressure.
- **Reset mid-operation:** all in-flight addresses, enables and init pulses are discarded. Nothing is replayed after release.
- **Simultaneous `rd_en` edges and `init_in`:** these are independent. Each is delayed according to its own rule.

## Test plan
1. **Reset values.**
   - Stimulus: hold `rst`=0 with `rd_en`=1 and `rd_addr_A`=5.
   - Required: `rd_en_A_bram`=4'b0001, `rd_addr_A_bram[0]`=5, all other lanes 0, `init_pe`=0.
2. **Address skew.**
   - Stimulus: release reset, set `rd_en`=1, ramp `rd_addr_A` and `rd_addr_B` through 0..15 one per cycle.
   - Required: `rd_addr_A_bram[3]` shows 0 three cycles after lane 0 does. At any cycle, lane i = lane 0 value − i (mod 16).
   - Required: `rd_en_A_bram` goes 0001 → 0011 → 0111 → 1111 over consecutive cycles. B behaves identically.
3. **Single enable pulse.**
   - Stimulus: `rd_en` high for one cycle at cycle t.
   - Required: `rd_en_B_bram[j]` is high only at cycle t+j, for j = 0..3.
4. **Init fan-out.**
   - Stimulus: one-cycle `init_in` at cycle t.
   - Required:
     - `init_pe[0]` (PE 0,0) is high only at t+1.
     - PE(1,2) is high only at t+4.
     - PE(3,3) (bit 15) is high only at t+7.
     - Exactly one pulse per bit.
5. **Asynchronous reset mid-stream.**
   - Stimulus: during test 4, drive `rst` low between clock edges at t+3.
   - Required: all `init_pe` bits and all lane≥1 outputs drop to 0 immediately, and no pulses appear after release.
6. **Asymmetric configuration.**
   - Stimulus: N1=2, N2=4, M=8.
   - Required: `AW_A`=5 and `AW_B`=4. A delays are 0 and 1; B delays are 0..3. PE(1,3) init latency is 5.
